// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared constants and state encoding for the UART word RX  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;
  localparam int BITCNT_W       = $clog2(DATA_BITS);
  localparam int MIN_DIV        = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_baud_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_baud_ctr : bit-period down-counter, tick when one cycle left |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx_baud_ctr #(
  parameter int BAUD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_half,
  input  logic              load_full,
  input  logic [BAUD_W-1:0] div,
  output logic              tick
);

  logic [BAUD_W-1:0] r_cnt;

  // A load of N produces the tick N cycles later; an unreloaded counter parks at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load_half) begin
      r_cnt <= div >> 1;
    end else if (load_full) begin
      r_cnt <= div;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tick = (r_cnt == BAUD_W'(1));

endmodule
`default_nettype wire

// File: rtl/uart_word_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_word_rx : UART receiver packing bytes into 32-bit words         |
// | Optional partial-word idle timeout: define UART_RX_TIMEOUT_EN        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int BAUD_W    = 24,
  parameter int IDLE_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic [BAUD_W-1:0] baudcontrol,
  input  logic              parity,
  output logic [31:0]       data_out,
  output logic [2:0]        nbytes,
  output logic              done,
  output logic              parity_err,
  output logic              frame_err
);

  logic                 r_rxd_meta, r_rxd_sync, r_rxd_prev;
  logic                 w_fall;
  logic [BAUD_W-1:0]    w_div;
  state_t               r_state, w_state_nxt;
  logic [BITCNT_W-1:0]  r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit, r_par_seen, r_frame_hold;
  logic [2:0]           r_idx;
  logic [31:0]          r_acc;
  logic                 w_tick, w_load_half, w_load_full;
  logic                 w_shift_en, w_par_sample, w_stop_sample;
  logic                 w_par_bad, w_byte_ok, w_frame_bad, w_par_err, w_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  assign w_fall = r_rxd_prev & ~r_rxd_sync;
  assign w_div  = (baudcontrol < BAUD_W'(MIN_DIV)) ? BAUD_W'(MIN_DIV) : baudcontrol;

  uart_rx_baud_ctr #(.BAUD_W(BAUD_W)) u_bit_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_half (w_load_half),
    .load_full (w_load_full),
    .div       (w_div),
    .tick      (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_half   = 1'b0;
    w_load_full   = 1'b0;
    w_shift_en    = 1'b0;
    w_par_sample  = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_load_half = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (!r_rxd_sync) begin
            w_state_nxt = DATA;
            w_load_full = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_en  = 1'b1;
          w_load_full = 1'b1;
          if (r_bitcnt == BITCNT_W'(DATA_BITS - 1))
            w_state_nxt = parity ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_par_sample = 1'b1;
          w_load_full  = 1'b1;
          w_state_nxt  = STOP;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line is released.
        if (r_frame_hold) begin
          if (r_rxd_sync) w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_stop_sample = 1'b1;
          if (r_rxd_sync) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_par_bad   = r_par_seen & (^{r_shift, r_par_bit});
  assign w_frame_bad = w_stop_sample & ~r_rxd_sync;
  assign w_par_err   = w_stop_sample & r_rxd_sync & w_par_bad;
  assign w_byte_ok   = w_stop_sample & r_rxd_sync & ~w_par_bad;

`ifdef UART_RX_TIMEOUT_EN
  localparam int IDLE_CNT_W = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

  logic                  r_idle_run;
  logic [IDLE_CNT_W-1:0] r_idle_bits;
  logic                  w_idle_active, w_idle_tick, w_idle_last, w_idle_load, w_to_commit;

  // Any low level on the line (including a new start edge) drops out of the active window.
  assign w_idle_active = (r_state == IDLE) && (r_idx != 3'd0)
                       && (r_idx < 3'(BYTES_PER_WORD)) && r_rxd_sync;
  assign w_idle_last   = (r_idle_bits == IDLE_CNT_W'(IDLE_BITS - 1));
  assign w_idle_load   = w_idle_active && (!r_idle_run || (w_idle_tick && !w_idle_last));
  assign w_to_commit   = w_idle_active && r_idle_run && w_idle_tick && w_idle_last;

  uart_rx_baud_ctr #(.BAUD_W(BAUD_W)) u_idle_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_half (1'b0),
    .load_full (w_idle_load),
    .div       (w_div),
    .tick      (w_idle_tick)
  );

  always_ff @(posedge clk) begin
    if (rst || !w_idle_active) begin
      r_idle_run  <= 1'b0;
      r_idle_bits <= '0;
    end else if (!r_idle_run) begin
      r_idle_run  <= 1'b1;
    end else if (w_idle_tick) begin
      r_idle_bits <= r_idle_bits + 1'b1;
    end
  end

  assign w_commit = (r_idx == 3'(BYTES_PER_WORD)) | w_to_commit;
`else
  assign w_commit = (r_idx == 3'(BYTES_PER_WORD));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_par_seen   <= 1'b0;
      r_frame_hold <= 1'b0;
      r_idx        <= '0;
      r_acc        <= '0;
      data_out     <= '0;
      nbytes       <= '0;
      done         <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      done       <= w_commit;
      parity_err <= w_par_err;
      frame_err  <= w_frame_bad;

      if (w_load_half) begin
        r_bitcnt     <= '0;
        r_par_seen   <= 1'b0;
        r_frame_hold <= 1'b0;
      end
      if (w_shift_en) begin
        r_shift  <= {r_rxd_sync, r_shift[DATA_BITS-1:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_par_sample) begin
        r_par_bit  <= r_rxd_sync;
        r_par_seen <= 1'b1;
      end
      if (w_frame_bad) r_frame_hold <= 1'b1;

      // Commits only happen in IDLE, so they never coincide with a byte write.
      if (w_commit) begin
        data_out <= r_acc;
        nbytes   <= r_idx;
        r_acc    <= '0;
        r_idx    <= '0;
      end else if (w_byte_ok) begin
        r_acc[{r_idx[1:0], 3'b000} +: DATA_BITS] <= r_shift;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
